reg_write_arbiter: RTL and testbench
====================================

# reg_write_arbiter

Two-requester write arbiter for the shared 16-bit storage register. It accepts write requests from two independent ports and grants one per transaction with round-robin priority. It writes the winning data into the register and returns a one-cycle acknowledge to the winner. It sits between the datapath producers and the register, replacing the static `choice` select with request/acknowledge sequencing.

## Interface
- `WIDTH`, 16, data and register width
- `CNT_WIDTH`, 8, width of per-port write counters
- `clk`  in  1  clock; all state updates on the rising edge
- `reset`  in  1  asynchronous, active-low reset
- `req_1`  in  1  port 1 write request; held until `ack_1`
- `data_1`  in  WIDTH  port 1 write data; stable while `req_1` is high
- `req_2`  in  1  port 2 write request
- `data_2`  in  WIDTH  port 2 write data
- `ack_1`  out  1  one-cycle acknowledge to port 1
- `ack_2`  out  1  one-cycle acknowledge to port 2
- `read_port_1`  out  WIDTH  current register contents
- `valid`  out  1  register written at least once since reset
- `last_src`  out  1  source of last write: 0 = port 1, 1 = port 2
- `wr_count_1`  out  CNT_WIDTH  saturating count of port 1 writes
- `wr_count_2`  out  CNT_WIDTH  saturating count of port 2 writes

## Operation
- FSM states: IDLE, ACK1, ACK2. Priority pointer `prio` (0 = port 1 favoured, 1 = port 2 favoured).
- IDLE handling:
  - Only `req_1` high: write `data_1` into the register, set `last_src`=0, `prio`=1, increment `wr_count_1`, go to ACK1.
  - Only `req_2` high: the same with port 2 data and `wr_count_2`; set `prio`=0 and go to ACK2.
  - Both high: grant the port `prio` favours.
  - Neither high: stay in IDLE with no change.
- ACK1/ACK2: the matching `ack_x` is high for this cycle only. Requests are ignored, and the next state is always IDLE.
- Requester rules:
  - Drop `req_x` in the cycle `ack_x` is high.
  - A `req_x` still high when the FSM is back in IDLE is a new request and is arbitrated normally, which writes again.
- Counters saturate at 2^CNT_WIDTH−1 (255) and do not wrap.
- `valid` sets on the first write and clears only on reset.
- The register holds its value whenever no grant occurs.
- `ack_1` and `ack_2` are mutually exclusive.

## Timing
- Reset (`reset`=0, asynchronous), all immediate:
  - state IDLE, `prio`=0
  - `read_port_1`=0, `ack_1`=`ack_2`=0
  - `valid`=0, `last_src`=0, both counters 0
- Grant latency: a request sampled high in IDLE at edge N has these effects:
  - `read_port_1`, `last_src`, `valid` and the counter update at edge N.
  - `ack_x` is high from edge N until edge N+1.
- Throughput is at most one write per 2 cycles. Alternating service under continuous contention gives each port one write per 4 cycles.
- Reset asserted mid-operation (including during ACK1/ACK2):
  - Any pending ack is cancelled immediately.
  - No write occurs while `reset`=0.
  - After release, the first rising edge evaluates in IDLE with port 1 favoured.
- Request rising in an ACK cycle: not granted until the following IDLE cycle.
- All outputs are registered; there are no combinational input-to-output paths.

## Test plan
- Reset then single port: hold `reset`=0 for 20 ns, release, raise `req_1` with `data_1`=65.
  - Next edge: `read_port_1`=65, `last_src`=0, `valid`=1, `wr_count_1`=1.
  - `ack_1` is high for exactly one cycle.
- Contention alternation: `req_1`=1 with `data_1`=32, and `req_2`=1 with `data_2`=4, held high throughout.
  - Grants go port 1, port 2, port 1, with `read_port_1` = 32, 4, 32.
  - Acks alternate with one idle-evaluation cycle between them; `ack_1` and `ack_2` are never high together.
- Priority memory: port 2 writes 924 alone, then both request (`data_1`=241, `data_2`=6202).
  - Port 1 wins first because `prio`=0 after the port 2 grant.
- Mid-transaction reset: assert `reset`=0 in the ACK2 cycle after writing 3263.
  - `ack_2` drops immediately; `read_port_1`=0, `valid`=0, counters are 0.
  - Requests during reset cause no write.
- Saturation: 300 port 2 writes → `wr_count_2`=255 and stays there; `wr_count_1` is unchanged.
- Hold: no requests for 10 cycles after writing 198 → `read_port_1` stays 198 and no ack is asserted.

Source files
------------

// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: two-port round-robin write arbiter for the shared
// WIDTH-bit storage register. Each grant writes the winner's data, updates
// the source/valid flags and the winner's saturating write counter, and
// returns a one-cycle acknowledge. Every output comes straight from a flop.
module reg_write_arbiter #(
  parameter int WIDTH     = 16,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_1,
  input  logic [WIDTH-1:0]     data_1,
  input  logic                 req_2,
  input  logic [WIDTH-1:0]     data_2,
  output logic                 ack_1,
  output logic                 ack_2,
  output logic [WIDTH-1:0]     read_port_1,
  output logic                 valid,
  output logic                 last_src,
  output logic [CNT_WIDTH-1:0] wr_count_1,
  output logic [CNT_WIDTH-1:0] wr_count_2
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACK1 = 2'd1,
    S_ACK2 = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t               r_state;
  logic                 r_prio;      // 0: port 1 favoured, 1: port 2 favoured
  logic [WIDTH-1:0]     r_data;
  logic                 r_valid;
  logic                 r_last_src;
  logic [CNT_WIDTH-1:0] r_cnt_1;
  logic [CNT_WIDTH-1:0] r_cnt_2;
  logic                 r_ack_1;
  logic                 r_ack_2;

  logic                 w_idle;
  logic                 w_grant_1;
  logic                 w_grant_2;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : (v + CNT_ONE);
  endfunction

  // Requests only count in IDLE; a lone requester always wins, and under
  // contention the priority pointer picks the port that was not served last.
  assign w_idle    = (r_state == S_IDLE);
  assign w_grant_1 = w_idle && req_1 && (!req_2 || !r_prio);
  assign w_grant_2 = w_idle && req_2 && (!req_1 ||  r_prio);

  // Arbitration FSM: IDLE grants and writes, ACK1/ACK2 hold the ack for one
  // cycle while ignoring requests, then fall back to IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_prio     <= 1'b0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_last_src <= 1'b0;
      r_cnt_1    <= '0;
      r_cnt_2    <= '0;
      r_ack_1    <= 1'b0;
      r_ack_2    <= 1'b0;
    end else begin
      r_ack_1 <= 1'b0;
      r_ack_2 <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_grant_1) begin
            r_data     <= data_1;
            r_last_src <= 1'b0;
            r_valid    <= 1'b1;
            r_prio     <= 1'b1;
            r_cnt_1    <= sat_inc(r_cnt_1);
            r_ack_1    <= 1'b1;
            r_state    <= S_ACK1;
          end else if (w_grant_2) begin
            r_data     <= data_2;
            r_last_src <= 1'b1;
            r_valid    <= 1'b1;
            r_prio     <= 1'b0;
            r_cnt_2    <= sat_inc(r_cnt_2);
            r_ack_2    <= 1'b1;
            r_state    <= S_ACK2;
          end
        end
        S_ACK1:  r_state <= S_IDLE;
        S_ACK2:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ack_1       = r_ack_1;
  assign ack_2       = r_ack_2;
  assign read_port_1 = r_data;
  assign valid       = r_valid;
  assign last_src    = r_last_src;
  assign wr_count_1  = r_cnt_1;
  assign wr_count_2  = r_cnt_2;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb_reg_write_arbiter: scoreboard bench. The driver predicts each grant
// from a transaction-level model (round-robin order, saturating counts) and
// queues it; the monitor pops and compares whenever an ack appears.
module tb_reg_write_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_1, req_2;
  logic [15:0] data_1, data_2;
  logic        ack_1, ack_2;
  logic [15:0] read_port_1;
  logic        valid, last_src;
  logic [7:0]  wr_count_1, wr_count_2;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic        src;
    logic [15:0] data;
    logic [7:0]  c1;
    logic [7:0]  c2;
  } exp_t;

  exp_t sbq[$];

  // reference model state
  bit m_prio;
  int m_c1, m_c2;

  always #5 clk = ~clk;

  reg_write_arbiter #(.WIDTH(16), .CNT_WIDTH(8)) dut (
    .clk(clk), .reset(reset),
    .req_1(req_1), .data_1(data_1),
    .req_2(req_2), .data_2(data_2),
    .ack_1(ack_1), .ack_2(ack_2),
    .read_port_1(read_port_1), .valid(valid), .last_src(last_src),
    .wr_count_1(wr_count_1), .wr_count_2(wr_count_2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // The served port loses priority; its counter grows up to 255.
  function automatic void model_grant(input bit src, input logic [15:0] d);
    exp_t e;
    if (src == 1'b0) m_c1 = (m_c1 < 255) ? m_c1 + 1 : 255;
    else             m_c2 = (m_c2 < 255) ? m_c2 + 1 : 255;
    m_prio = !src;
    e.src  = src;
    e.data = d;
    e.c1   = 8'(m_c1);
    e.c2   = 8'(m_c2);
    sbq.push_back(e);
  endfunction

  function automatic void model_reset();
    m_prio = 1'b0;
    m_c1   = 0;
    m_c2   = 0;
    sbq.delete();
  endfunction

  // One transaction: each selected port holds its request until acked.
  task automatic run_txn(input bit r1, input bit r2, input logic [15:0] d1, input logic [15:0] d2);
    if (r1 && r2) begin
      if (!m_prio) begin model_grant(1'b0, d1); model_grant(1'b1, d2); end
      else         begin model_grant(1'b1, d2); model_grant(1'b0, d1); end
    end else if (r1) model_grant(1'b0, d1);
    else if (r2)     model_grant(1'b1, d2);
    req_1 = r1; data_1 = d1;
    req_2 = r2; data_2 = d2;
    for (int i = 0; i < 20 && (req_1 || req_2); i++) begin
      @(negedge clk);
      if (ack_1) req_1 = 1'b0;
      if (ack_2) req_2 = 1'b0;
    end
    if (req_1 || req_2) begin
      total++; bad++;
      $display("FAIL txn_timeout actual=no_ack required=ack");
      req_1 = 1'b0; req_2 = 1'b0;
    end
  endtask

  // Both ports request continuously until n grants have been seen.
  task automatic hold_both(input logic [15:0] d1, input logic [15:0] d2, input int n);
    int seen = 0;
    for (int k = 0; k < n; k++) model_grant(m_prio, m_prio ? d2 : d1);
    req_1 = 1'b1; data_1 = d1;
    req_2 = 1'b1; data_2 = d2;
    for (int i = 0; i < 4*n + 10 && seen < n; i++) begin
      @(negedge clk);
      if (ack_1 || ack_2) seen++;
    end
    req_1 = 1'b0; req_2 = 1'b0;
    if (seen < n) begin
      total++; bad++;
      $display("FAIL contention_timeout actual=%0d required=%0d", seen, n);
    end
  endtask

  // Monitor: every ack must match the next predicted grant.
  initial begin
    logic p1, p2;
    exp_t e;
    p1 = 1'b0; p2 = 1'b0;
    forever begin
      @(negedge clk);
      if (ack_1 || ack_2) begin
        chk("ack_mutex", 32'(ack_1 & ack_2), 0);
        chk("ack_one_cycle", 32'((ack_1 & p1) | (ack_2 & p2)), 0);
        if (sbq.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_ack actual=ack1:%0b,ack2:%0b required=none", ack_1, ack_2);
        end else begin
          e = sbq.pop_front();
          chk("grant_src",   32'(ack_2),      32'(e.src));
          chk("read_port_1", 32'(read_port_1), 32'(e.data));
          chk("last_src",    32'(last_src),    32'(e.src));
          chk("valid",       32'(valid),       1);
          chk("wr_count_1",  32'(wr_count_1),  32'(e.c1));
          chk("wr_count_2",  32'(wr_count_2),  32'(e.c2));
        end
      end
      p1 = ack_1;
      p2 = ack_2;
    end
  end

  initial begin
    int s;
    reset = 1'b0;
    req_1 = 1'b0; req_2 = 1'b0;
    data_1 = '0;  data_2 = '0;
    model_reset();

    // reset state
    #3;
    chk("rst_read_port_1", 32'(read_port_1), 0);
    chk("rst_ack", 32'({ack_1, ack_2}), 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_last_src", 32'(last_src), 0);
    chk("rst_counts", 32'({wr_count_1, wr_count_2}), 0);
    #17;
    reset = 1'b1;

    // single port write, then priority memory, then continuous contention
    run_txn(1'b1, 1'b0, 16'd65, 16'd0);
    run_txn(1'b0, 1'b1, 16'd0, 16'd924);
    run_txn(1'b1, 1'b1, 16'd241, 16'd6202);
    hold_both(16'd32, 16'd4, 3);

    // hold: register stays put with no requests
    run_txn(1'b1, 1'b0, 16'd198, 16'd0);
    repeat (10) begin
      @(negedge clk);
      chk("hold_read_port_1", 32'(read_port_1), 198);
      chk("hold_no_ack", 32'({ack_1, ack_2}), 0);
    end

    // saturation of port 2 counter
    repeat (300) run_txn(1'b0, 1'b1, 16'd0, 16'($urandom));
    chk("sat_wr_count_2", 32'(wr_count_2), 255);
    chk("sat_wr_count_1", 32'(wr_count_1), 32'(m_c1));

    // reset in the ACK2 cycle
    req_2 = 1'b1; data_2 = 16'd3263;
    model_grant(1'b1, 16'd3263);
    for (int i = 0; i < 10 && !ack_2; i++) @(negedge clk);
    if (!ack_2) begin
      total++; bad++;
      $display("FAIL midrst_no_ack actual=0 required=1");
    end
    #1 reset = 1'b0;
    #1;
    chk("midrst_ack_2", 32'(ack_2), 0);
    chk("midrst_read_port_1", 32'(read_port_1), 0);
    chk("midrst_valid", 32'(valid), 0);
    chk("midrst_counts", 32'({wr_count_1, wr_count_2}), 0);
    model_reset();
    req_1 = 1'b1; req_2 = 1'b1;
    data_1 = 16'h1234; data_2 = 16'h5678;
    repeat (3) begin
      @(negedge clk);
      chk("inrst_no_ack", 32'({ack_1, ack_2}), 0);
      chk("inrst_read_port_1", 32'(read_port_1), 0);
      chk("inrst_valid", 32'(valid), 0);
    end
    req_1 = 1'b0; req_2 = 1'b0;
    reset = 1'b1;

    // port 1 favoured right after reset
    run_txn(1'b1, 1'b1, 16'd111, 16'd222);

    // randomized traffic
    repeat (200) begin
      s = $urandom_range(1, 3);
      run_txn(s[0], s[1], 16'($urandom), 16'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    chk("scoreboard_empty", 32'(sbq.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
